// File: rtl/count_burst_ctrl_if.sv
// count_burst_ctrl_if
//   Control and status bundle between the ui_in control pins and the burst
//   sequencer that drives the counter enable.
//   master : drives start/len/pause/abort, observes the status outputs.
//   slave  : the sequencer itself.
//   Signals: start (burst request), len (increment count), pause, abort,
//            cnt_en (counter increment enable), busy, done (one-cycle pulse),
//            remaining (increments still to issue), state (IDLE=0 RUN=1 DONE=2).
interface count_burst_ctrl_if #(
    parameter int CNT_W = 4
);
    logic             start;
    logic [CNT_W-1:0] len;
    logic             pause;
    logic             abort;
    logic             cnt_en;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] remaining;
    logic [1:0]       state;

    modport master (
        output start, len, pause, abort,
        input  cnt_en, busy, done, remaining, state
    );

    modport slave (
        input  start, len, pause, abort,
        output cnt_en, busy, done, remaining, state
    );
endinterface

// File: rtl/count_burst_ctrl.sv
// count_burst_ctrl
//   Burst sequencer owning the enable of the shared up-counter. A start
//   request issues exactly len single-cycle increment enables, one every DIV
//   clock cycles, with pause (hold) and abort (cancel, no done pulse).
//   Ports:
//     clk   - single clock, rising edge
//     rst_n - synchronous reset, active HIGH despite its name
//     bus   - count_burst_ctrl_if.slave (start, len, pause, abort in;
//             cnt_en, busy, done, remaining, state out)
//   Parameters: CNT_W (len/remaining width), DIV (cycles per enable, 1..255),
//               PRE_W (prescaler width, 2^PRE_W > DIV-1).
//   Optional feature macro: CTRL_AUTO_RELOAD_EN -- when defined, a start held
//   high at the final enable of a burst reloads len and keeps running.
module count_burst_ctrl #(
    parameter int CNT_W = 4,
    parameter int DIV   = 1,
    parameter int PRE_W = 8
) (
    input logic                clk,
    input logic                rst_n,
    count_burst_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] remaining_q;
    logic [PRE_W-1:0] pre_q;

    logic pre_last;
    logic cnt_en_w;
    logic last_en;
    logic reload;

    assign pre_last = (pre_q == PRE_W'(DIV - 1));
    assign cnt_en_w = (state_q == RUN) & ~bus.pause & ~bus.abort & pre_last;
    assign last_en  = cnt_en_w & (remaining_q == CNT_W'(1));

`ifdef CTRL_AUTO_RELOAD_EN
    // A fresh request present at the final enable chains a new burst.
    assign reload = last_en & bus.start & (bus.len != '0);
`else
    assign reload = 1'b0;
`endif

    assign bus.cnt_en    = cnt_en_w;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE) | reload;
    assign bus.remaining = remaining_q;
    assign bus.state     = state_q;

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            pre_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start && !bus.abort) begin
                        if (bus.len != '0) begin
                            remaining_q <= bus.len;
                            pre_q       <= '0;
                            state_q     <= RUN;
                        end else begin
                            state_q <= DONE;
                        end
                    end
                end
                RUN: begin
                    if (bus.abort) begin
                        remaining_q <= '0;
                        pre_q       <= '0;
                        state_q     <= IDLE;
                    end else if (bus.pause) begin
                        // hold everything
                    end else if (cnt_en_w) begin
                        pre_q <= '0;
                        if (reload) begin
                            remaining_q <= bus.len;
                        end else begin
                            remaining_q <= remaining_q - CNT_W'(1);
                            if (last_en) begin
                                state_q <= DONE;
                            end
                        end
                    end else begin
                        pre_q <= pre_q + PRE_W'(1);
                    end
                end
                DONE: begin
                    // abort is ignored here: completion is already committed
                    state_q <= IDLE;
                end
                default: begin
                    // unused encoding recovers to a clean IDLE
                    state_q     <= IDLE;
                    remaining_q <= '0;
                    pre_q       <= '0;
                end
            endcase
        end
    end

endmodule
